sprite_queue: RTL and testbench
===============================

Name: sprite_queue

Overview:
- Sprite draw-command FIFO sitting between the game-logic/host command writer and sprite_driver.
- Producer side: valid/ready enqueue of {id, x, y, scale} records.
- Consumer side: the show-ahead dequeue/is_empty interface that sprite_driver's distributor reads.
- Supports a per-frame flush, an occupancy count and a sticky overflow flag for software diagnostics.

Parameters:
DEPTH, 64, number of entries; power of two, 2..256.
CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived, not overridden).

Ports:
clock  input  1  single system clock, all logic posedge.
reset_n  input  1  asynchronous active-low reset.
enq_valid  input  1  producer offers a record this cycle.
enq_ready  output  1  queue can accept; equals (count < DEPTH).
enq_sprite_id  input  8  sprite index.
enq_sprite_x  input  16  x position.
enq_sprite_y  input  16  y position.
enq_sprite_scale  input  8  scale factor.
flush  input  1  synchronous clear of all entries and the overflow flag.
sprite_queue_dequeue  input  1  consumer pops the head entry.
sprite_queue_is_empty  output  1  high when count == 0.
sprite_queue_sprite_id  output  8  head entry id.
sprite_queue_sprite_x  output  16  head entry x.
sprite_queue_sprite_y  output  16  head entry y.
sprite_queue_sprite_scale  output  8  head entry scale.
count  output  CNT_W  current occupancy.
overflow  output  1  sticky: an enqueue was attempted while full.

Behaviour:
- Storage:
  - DEPTH x 48-bit register array.
  - wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count is a separate CNT_W register.
- Reset (reset_n low, asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0, overflow = 0.
  - Resulting outputs: is_empty = 1, enq_ready = 1, head fields = 0.
  - Array contents are don't-care.
  - Deassertion is synchronous to clock via the standard 2-flop reset synchroniser.
- Enqueue:
  - A record is accepted at a rising edge where enq_valid && enq_ready.
  - The record is written at mem[wr_ptr], then wr_ptr += 1.
- Dequeue:
  - Takes effect at a rising edge where sprite_queue_dequeue && !sprite_queue_is_empty; rd_ptr += 1.
  - Dequeue while empty is ignored: no pointer or count change, no error flag.
- Show-ahead:
  - Head fields are combinational from mem[rd_ptr] whenever count > 0.
  - Head fields are forced to 0 when empty.
  - The consumer samples the head in the same cycle it asserts dequeue.
- Latency:
  - A record accepted at edge N is visible on the head (is_empty low) in the cycle after edge N.
  - After a dequeue at edge N, the next entry is visible in the cycle after edge N.
- Count update:
  - Enqueue only: +1. Dequeue only: -1. Both: unchanged.
  - Simultaneous enqueue+dequeue is legal at any occupancy where enq_ready = 1.
- Full queue:
  - enq_ready = 0 at count == DEPTH.
  - enq_ready does not depend combinationally on dequeue, so a same-cycle pop does not admit a push when full.
- Overflow:
  - enq_valid && !enq_ready at an edge sets overflow to 1.
  - The record is dropped.
  - overflow holds until flush or reset.
- Flush:
  - At an edge with flush = 1: wr_ptr = rd_ptr = 0, count = 0, overflow = 0.
  - Any enqueue or dequeue in the same cycle is discarded.
  - Flush has priority over everything except reset.
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no gap; FIFO ordering is preserved across the wrap.
- Reset mid-operation: all in-flight entries are lost; the queue reads empty immediately (asynchronous).
- Output stability: no output glitches on enqueue into a non-empty queue; head is unchanged unless dequeued.

Test Plan:
- Reset, then enqueue {id=3, x=100, y=50, scale=2} at edge N → in the cycle after N: is_empty = 0, head = {3, 100, 50, 2}, count = 1. Dequeue at the next edge → is_empty = 1, head = 0, count = 0.
- DEPTH = 64: enqueue ids 0..63 with no dequeue → count = 64, enq_ready = 0. Offer id 64 → overflow = 1, count stays 64. Dequeue all → ids read 0..63 in order.
- Fill to 10, then assert enq_valid and dequeue together for 200 cycles with incrementing ids → count stays 10, ids pop strictly in order, pointers wrap three times.
- Full queue with enq_valid and dequeue both high → dequeue happens, record not accepted, overflow = 1, count goes to 63.
- Count = 5 with overflow = 1; assert flush together with enq_valid and dequeue → next cycle: count = 0, is_empty = 1, overflow = 0, the enqueued record is absent.
- Count = 7; pulse reset_n low between clock edges → is_empty = 1 and count = 0 without waiting for an edge. After release, a single enqueue round-trips correctly.

Source files
------------

// File: rtl/sprite_queue.sv
// Sprite draw-command FIFO between the host command writer and sprite_driver.
// Producer uses valid/ready; consumer sees a show-ahead head with dequeue/is_empty.
// Also provides a per-frame flush, an occupancy count and a sticky overflow flag.
module sprite_queue #(
  parameter  int DEPTH = 64,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [7:0]       enq_sprite_id,
  input  logic [15:0]      enq_sprite_x,
  input  logic [15:0]      enq_sprite_y,
  input  logic [7:0]       enq_sprite_scale,
  input  logic             flush,
  input  logic             sprite_queue_dequeue,
  output logic             sprite_queue_is_empty,
  output logic [7:0]       sprite_queue_sprite_id,
  output logic [15:0]      sprite_queue_sprite_x,
  output logic [15:0]      sprite_queue_sprite_y,
  output logic [7:0]       sprite_queue_sprite_scale,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // Record layout: {id, x, y, scale}
  logic [47:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic [1:0]       rst_sync_r;
  logic             rst_int_n_s;
  logic             empty_s;
  logic             ready_s;
  logic             enq_fire_s;
  logic             deq_fire_s;
  logic [47:0]      head_s;

  // Reset synchroniser: assert immediately, release two clock edges after reset_n rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  // Full/empty come from the count register only, so a same-cycle pop never admits a push when full.
  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign ready_s    = (count_r < CNT_W'(DEPTH));
  assign enq_fire_s = enq_valid && ready_s;
  assign deq_fire_s = sprite_queue_dequeue && !empty_s;

  // Pointer, occupancy and sticky overflow state; flush outranks every other update.
  always_ff @(posedge clock or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (enq_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (deq_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({enq_fire_s, deq_fire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (enq_valid && !ready_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Record storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (rst_int_n_s && !flush && enq_fire_s) begin
      mem_r[wr_ptr_r] <= {enq_sprite_id, enq_sprite_x, enq_sprite_y, enq_sprite_scale};
    end
  end

  // Show-ahead head: the entry at rd_ptr, forced to zero when the queue is empty.
  always_comb begin
    head_s = 48'd0;
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = 48'd0;
    end
  end

  assign enq_ready                 = ready_s;
  assign sprite_queue_is_empty     = empty_s;
  assign sprite_queue_sprite_id    = head_s[47:40];
  assign sprite_queue_sprite_x     = head_s[39:24];
  assign sprite_queue_sprite_y     = head_s[23:8];
  assign sprite_queue_sprite_scale = head_s[7:0];
  assign count                     = count_r;
  assign overflow                  = overflow_r;

endmodule

// File: tb/tb_sprite_queue.sv
// Directed self-checking bench for sprite_queue (DEPTH = 64).
module tb_sprite_queue;

  localparam int DEPTH = 64;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clock;
  logic             reset_n;
  logic             enq_valid;
  logic             enq_ready;
  logic [7:0]       enq_sprite_id;
  logic [15:0]      enq_sprite_x;
  logic [15:0]      enq_sprite_y;
  logic [7:0]       enq_sprite_scale;
  logic             flush;
  logic             sprite_queue_dequeue;
  logic             sprite_queue_is_empty;
  logic [7:0]       sprite_queue_sprite_id;
  logic [15:0]      sprite_queue_sprite_x;
  logic [15:0]      sprite_queue_sprite_y;
  logic [7:0]       sprite_queue_sprite_scale;
  logic [CNT_W-1:0] count;
  logic             overflow;

  int checks_r;
  int failures_r;

  sprite_queue #(.DEPTH(DEPTH)) dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .enq_valid                 (enq_valid),
    .enq_ready                 (enq_ready),
    .enq_sprite_id             (enq_sprite_id),
    .enq_sprite_x              (enq_sprite_x),
    .enq_sprite_y              (enq_sprite_y),
    .enq_sprite_scale          (enq_sprite_scale),
    .flush                     (flush),
    .sprite_queue_dequeue      (sprite_queue_dequeue),
    .sprite_queue_is_empty     (sprite_queue_is_empty),
    .sprite_queue_sprite_id    (sprite_queue_sprite_id),
    .sprite_queue_sprite_x     (sprite_queue_sprite_x),
    .sprite_queue_sprite_y     (sprite_queue_sprite_y),
    .sprite_queue_sprite_scale (sprite_queue_sprite_scale),
    .count                     (count),
    .overflow                  (overflow)
  );

  // 100 MHz clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r = checks_r + 1;
    if (got !== exp) begin
      failures_r = failures_r + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                      input logic [7:0] s);
    enq_sprite_id    = id;
    enq_sprite_x     = x;
    enq_sprite_y     = y;
    enq_sprite_scale = s;
    enq_valid        = 1'b1;
    tick();
    enq_valid        = 1'b0;
  endtask

  task automatic pop();
    sprite_queue_dequeue = 1'b1;
    tick();
    sprite_queue_dequeue = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic fill_full();
    for (int i = 0; i < DEPTH; i++) begin
      push(8'(i), 16'(1000 + i), 16'(i * 3), 8'(i + 1));
    end
  endtask

  initial begin
    checks_r             = 0;
    failures_r           = 0;
    reset_n              = 1'b0;
    enq_valid            = 1'b0;
    enq_sprite_id        = 8'd0;
    enq_sprite_x         = 16'd0;
    enq_sprite_y         = 16'd0;
    enq_sprite_scale     = 8'd0;
    flush                = 1'b0;
    sprite_queue_dequeue = 1'b0;

    // Reset state
    #2;
    check("rst_empty", 32'(sprite_queue_is_empty), 32'd1);
    check("rst_ready", 32'(enq_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_head_id", 32'(sprite_queue_sprite_id), 32'd0);
    #20;
    reset_n = 1'b1;
    repeat (3) tick();

    // Single round trip
    push(8'd3, 16'd100, 16'd50, 8'd2);
    check("rt_empty", 32'(sprite_queue_is_empty), 32'd0);
    check("rt_id", 32'(sprite_queue_sprite_id), 32'd3);
    check("rt_x", 32'(sprite_queue_sprite_x), 32'd100);
    check("rt_y", 32'(sprite_queue_sprite_y), 32'd50);
    check("rt_scale", 32'(sprite_queue_sprite_scale), 32'd2);
    check("rt_count", 32'(count), 32'd1);
    pop();
    check("rt_empty2", 32'(sprite_queue_is_empty), 32'd1);
    check("rt_head0", 32'(sprite_queue_sprite_x), 32'd0);
    check("rt_count0", 32'(count), 32'd0);

    // Dequeue while empty is ignored
    pop();
    check("emp_deq_count", 32'(count), 32'd0);
    check("emp_deq_ovf", 32'(overflow), 32'd0);

    // Fill to full, overflow, drain in order
    fill_full();
    check("full_count", 32'(count), 32'd64);
    check("full_ready", 32'(enq_ready), 32'd0);
    check("full_ovf0", 32'(overflow), 32'd0);
    push(8'd64, 16'd7, 16'd7, 8'd7);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd64);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_id", 32'(sprite_queue_sprite_id), 32'(i));
      check("drain_x", 32'(sprite_queue_sprite_x), 32'(1000 + i));
      pop();
    end
    check("drain_empty", 32'(sprite_queue_is_empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    do_flush();
    check("flush_ovf", 32'(overflow), 32'd0);

    // Steady-state streaming at count 10 across pointer wraps
    for (int i = 0; i < 10; i++) begin
      push(8'(i), 16'(i), 16'd0, 8'd0);
    end
    check("stream_fill", 32'(count), 32'd10);
    for (int i = 10; i < 210; i++) begin
      check("stream_id", 32'(sprite_queue_sprite_id), 32'(i - 10));
      enq_sprite_id        = 8'(i);
      enq_sprite_x         = 16'(i);
      enq_valid            = 1'b1;
      sprite_queue_dequeue = 1'b1;
      tick();
    end
    enq_valid            = 1'b0;
    sprite_queue_dequeue = 1'b0;
    check("stream_count", 32'(count), 32'd10);
    for (int i = 200; i < 210; i++) begin
      check("stream_tail", 32'(sprite_queue_sprite_id), 32'(i));
      pop();
    end
    check("stream_empty", 32'(sprite_queue_is_empty), 32'd1);

    // Full with push and pop together: pop wins, push dropped, overflow set
    fill_full();
    enq_sprite_id        = 8'hAA;
    enq_valid            = 1'b1;
    sprite_queue_dequeue = 1'b1;
    tick();
    enq_valid            = 1'b0;
    sprite_queue_dequeue = 1'b0;
    check("fpp_count", 32'(count), 32'd63);
    check("fpp_ovf", 32'(overflow), 32'd1);
    check("fpp_ready", 32'(enq_ready), 32'd1);
    for (int i = 1; i < DEPTH; i++) begin
      check("fpp_id", 32'(sprite_queue_sprite_id), 32'(i));
      pop();
    end
    check("fpp_empty", 32'(sprite_queue_is_empty), 32'd1);

    // Flush outranks same-cycle push and pop
    for (int i = 0; i < 5; i++) begin
      push(8'(20 + i), 16'd1, 16'd1, 8'd1);
    end
    check("fl_pre_count", 32'(count), 32'd5);
    check("fl_pre_ovf", 32'(overflow), 32'd1);
    enq_sprite_id        = 8'h55;
    enq_valid            = 1'b1;
    sprite_queue_dequeue = 1'b1;
    flush                = 1'b1;
    tick();
    enq_valid            = 1'b0;
    sprite_queue_dequeue = 1'b0;
    flush                = 1'b0;
    check("fl_count", 32'(count), 32'd0);
    check("fl_empty", 32'(sprite_queue_is_empty), 32'd1);
    check("fl_ovf", 32'(overflow), 32'd0);
    tick();
    check("fl_absent", 32'(sprite_queue_is_empty), 32'd1);

    // Asynchronous reset between edges
    for (int i = 0; i < 7; i++) begin
      push(8'(40 + i), 16'd2, 16'd2, 8'd2);
    end
    check("ar_pre_count", 32'(count), 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_empty", 32'(sprite_queue_is_empty), 32'd1);
    check("ar_count", 32'(count), 32'd0);
    #2;
    reset_n = 1'b1;
    repeat (3) tick();
    push(8'd9, 16'd1234, 16'd5678, 8'd7);
    check("ar_rt_count", 32'(count), 32'd1);
    check("ar_rt_id", 32'(sprite_queue_sprite_id), 32'd9);
    check("ar_rt_x", 32'(sprite_queue_sprite_x), 32'd1234);
    check("ar_rt_y", 32'(sprite_queue_sprite_y), 32'd5678);
    check("ar_rt_scale", 32'(sprite_queue_sprite_scale), 32'd7);
    pop();
    check("ar_rt_empty", 32'(sprite_queue_is_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
